pll_dyn_ctrl: RTL
=================

PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
- REQ-001: Parameter NUM_CH, default 5, number of PLL output dividers controlled (1..5).
- REQ-002: Parameter RATIO_W, default 10, width of each ratio/duty field.
- REQ-003: Parameter DEFAULT_RATIO, default 16, ratio and duty loaded into every channel at reset.
- REQ-004: Parameter RST_CYCLES, default 16, cycles pll_rst is held per reset sequence (>=1).
- REQ-005: Parameter LOCK_FILTER, default 64, consecutive pll_lock-high cycles required to declare lock (>=1).
- REQ-006: Parameter LOCK_TIMEOUT, default 65535, cycles allowed in WAIT_LOCK before a retry.
- REQ-007: Parameter MAX_RETRY, default 3, retries allowed before ERROR.
- REQ-008: clk  input  1  single clock for all logic.
- REQ-009: rst  input  1  reset; synchronous, active-high.
- REQ-010: wr_en  input  1  write one shadow channel this cycle.
- REQ-011: wr_ch  input  3  channel index for the write.
- REQ-012: wr_ratio  input  RATIO_W  new divider ratio.
- REQ-013: wr_duty  input  RATIO_W  new duty value.
- REQ-014: apply  input  1  single-cycle request to commit the shadow set and relock.
- REQ-015: lock_lost_clr  input  1  clears sticky lock_lost.
- REQ-016: pll_lock  input  1  raw PLL lock, already synchronous to clk.
- REQ-017: pll_rst  output  1  PLL reset.
- REQ-018: dyn_ratio  output  NUM_CH*RATIO_W  active ratios, channel 0 in LSBs.
- REQ-019: dyn_duty  output  NUM_CH*RATIO_W  active duties, channel 0 in LSBs.
- REQ-020: locked  output  1  filtered lock, high only in LOCKED.
- REQ-021: busy  output  1  high in RST_PLL and WAIT_LOCK.
- REQ-022: err  output  1  high in ERROR.
- REQ-023: done  output  1  one-cycle pulse on entry to LOCKED.
- REQ-024: lock_lost  output  1  sticky lock-loss flag.

Function
- REQ-025: States RST_PLL, WAIT_LOCK, LOCKED, ERROR; one-hot or binary at implementer's choice.
- REQ-026: wr_en with wr_ch<NUM_CH SHALL update that shadow channel next cycle; wr_ch>=NUM_CH ignored; written ratio or duty of 0 stored as 1.
- REQ-027: Active registers (dyn_ratio/dyn_duty) change only when an accepted apply copies all shadow channels; they never change during RST_PLL or WAIT_LOCK.
- REQ-028: apply accepted only in LOCKED or ERROR; ignored while busy=1.
- REQ-029: apply and wr_en same cycle: the copy uses pre-write shadow contents; the write lands in shadow only.
- REQ-030: Accepted apply: active<=shadow, retry counter<=0, next state RST_PLL.
- REQ-031: RST_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with stable and timeout counters cleared.
- REQ-032: WAIT_LOCK: pll_rst=0; stable counter increments while pll_lock=1, clears to 0 on pll_lock=0; timeout counter increments every cycle.
- REQ-033: Stable counter reaching LOCK_FILTER: LOCKED next cycle, done=1 for that first LOCKED cycle; lock priority over timeout on the same cycle.
- REQ-034: Timeout counter reaching LOCK_TIMEOUT without lock: if retries<MAX_RETRY, retries+1 and RST_PLL; else ERROR.
- REQ-035: LOCKED: pll_lock=0 for one cycle sets lock_lost and enters RST_PLL with retries cleared; active ratios unchanged.
- REQ-036: LOCKED with apply and pll_lock=0 same cycle: apply copy performed and lock_lost set; next state RST_PLL.
- REQ-037: lock_lost set and lock_lost_clr same cycle: remains set.
- REQ-038: ERROR: pll_rst=0, held until accepted apply.
- REQ-039: Counters saturate; no wrap-around.

Reset
- REQ-040: rst=1 at any clock edge, including mid-sequence, SHALL force state RST_PLL, RST_CYCLES count restarted, pll_rst=1, all shadow and active fields=DEFAULT_RATIO, locked=0, busy=1, err=0, done=0, lock_lost=0, retries=0.

Verification
- REQ-041: Release rst, pll_lock=1 constantly -> pll_rst high 16 cycles, done pulses once 64 cycles later, dyn_ratio all 16.
- REQ-042: In LOCKED, write ch1 ratio 15, apply -> dyn_ratio[19:10]=15 next cycle, pll_rst 16 cycles, relock; ch0 stays 16.
- REQ-043: pll_lock tied 0, LOCK_TIMEOUT=100 -> four pll_rst pulses, then err=1, busy=0.
- REQ-044: In LOCKED, drop pll_lock one cycle -> lock_lost=1, relock sequence; lock_lost_clr -> lock_lost=0.
- REQ-045: wr_en ch2 ratio 0 and apply same cycle -> active ch2 stays old value; shadow ch2=1, seen after next apply.
- REQ-046: Assert rst in WAIT_LOCK, and apply while busy -> full reset values; apply ignored.

Source files
------------

// File: rtl/pll_dyn_ctrl.sv
// Dynamic PLL reconfiguration controller: shadow/active divider banks, PLL
// reset sequencing, filtered lock detection with timeout, retry and error.
module pll_dyn_ctrl #(
    parameter int NUM_CH        = 5,
    parameter int RATIO_W       = 10,
    parameter int DEFAULT_RATIO = 16,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_FILTER   = 64,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int MAX_RETRY     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [2:0]                wr_ch,
    input  logic [RATIO_W-1:0]        wr_ratio,
    input  logic [RATIO_W-1:0]        wr_duty,
    input  logic                      apply,
    input  logic                      lock_lost_clr,
    input  logic                      pll_lock,
    output logic                      pll_rst,
    output logic [NUM_CH*RATIO_W-1:0] dyn_ratio,
    output logic [NUM_CH*RATIO_W-1:0] dyn_duty,
    output logic                      locked,
    output logic                      busy,
    output logic                      err,
    output logic                      done,
    output logic                      lock_lost
);
    localparam int RST_W   = $clog2(RST_CYCLES + 1);
    localparam int FLT_W   = $clog2(LOCK_FILTER + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef logic [NUM_CH-1:0][RATIO_W-1:0] bank_t;
    localparam bank_t BANK_DEFAULT = {NUM_CH{RATIO_W'(DEFAULT_RATIO)}};

    // One-hot so each status output is a single state flop (busy is an OR of two).
    typedef enum logic [3:0] {
        S_RST_PLL   = 4'b0001,
        S_WAIT_LOCK = 4'b0010,
        S_LOCKED    = 4'b0100,
        S_ERROR     = 4'b1000
    } state_t;

    state_t               state;
    logic [RST_W-1:0]     rst_cnt;
    logic [FLT_W-1:0]     stable_cnt;
    logic [TO_W-1:0]      timeout_cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    bank_t                shadow_ratio, shadow_duty;
    bank_t                active_ratio, active_duty;

    assign pll_rst   = state[0];
    assign busy      = state[0] | state[1];
    assign locked    = state[2];
    assign err       = state[3];
    assign dyn_ratio = active_ratio;
    assign dyn_duty  = active_duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_RST_PLL;
            rst_cnt      <= '0;
            stable_cnt   <= '0;
            timeout_cnt  <= '0;
            retry_cnt    <= '0;
            // NOTE: the banks are reset because they define the PLL's power-up
            // configuration; they are small registers, not a RAM.
            shadow_ratio <= BANK_DEFAULT;
            shadow_duty  <= BANK_DEFAULT;
            active_ratio <= BANK_DEFAULT;
            active_duty  <= BANK_DEFAULT;
            done         <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            done <= 1'b0;

            // A zero divide ratio is illegal for the PLL, so it is stored as 1.
            if (wr_en && (int'(wr_ch) < NUM_CH)) begin
                shadow_ratio[wr_ch] <= (wr_ratio == '0) ? RATIO_W'(1) : wr_ratio;
                shadow_duty[wr_ch]  <= (wr_duty == '0) ? RATIO_W'(1) : wr_duty;
            end

            // NOTE: with non-blocking assignments the last one in the block wins,
            // so the lock-loss set further down overrides this clear.
            if (lock_lost_clr) lock_lost <= 1'b0;

            case (state)
                S_RST_PLL: begin
                    if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                        state       <= S_WAIT_LOCK;
                        rst_cnt     <= '0;
                        stable_cnt  <= '0;
                        timeout_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (pll_lock && (stable_cnt == FLT_W'(LOCK_FILTER - 1))) begin
                        state      <= S_LOCKED;
                        stable_cnt <= FLT_W'(LOCK_FILTER);
                        done       <= 1'b1;
                    end else begin
                        stable_cnt <= pll_lock ? stable_cnt + 1'b1 : '0;
                        if (timeout_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
                            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                state     <= S_RST_PLL;
                            end else begin
                                state <= S_ERROR;
                            end
                        end else begin
                            timeout_cnt <= timeout_cnt + 1'b1;
                        end
                    end
                end

                S_LOCKED: begin
                    if (apply) begin
                        active_ratio <= shadow_ratio;
                        active_duty  <= shadow_duty;
                        retry_cnt    <= '0;
                        state        <= S_RST_PLL;
                    end
                    if (!pll_lock) begin
                        lock_lost <= 1'b1;
                        retry_cnt <= '0;
                        state     <= S_RST_PLL;
                    end
                end

                S_ERROR: begin
                    if (apply) begin
                        active_ratio <= shadow_ratio;
                        active_duty  <= shadow_duty;
                        retry_cnt    <= '0;
                        state        <= S_RST_PLL;
                    end
                end

                default: state <= S_RST_PLL;
            endcase
        end
    end
endmodule
